// File: rtl/spi_reg_ctrl.sv
// SPI command decoder and configuration register bank, clocked on the system clock.
// Optional write-lock on address 0x3F is built in when SPI_WR_LOCK_EN is defined.
module spi_reg_ctrl #(
  parameter int         NREG    = 16,
  parameter logic [7:0] CHIP_ID = 8'h54
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                word_rcvd,
  input  logic [7:0]          cmd_byte,
  input  logic [7:0]          data_byte,
  input  logic [7:0]          status_in,
  output logic [15:0]         tx_buff,
  output logic [8*NREG-1:0]   regs_out,
  output logic                wr_strobe,
  output logic [5:0]          wr_addr,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, EXEC, RESP} state_t;

  state_t      state;
  logic        sync1, sync2, sync3;
  logic        go;
  logic [7:0]  cmd_q, data_q, err_cnt, err_next;
  logic [7:0]  regs [NREG];
  logic [15:0] resp_q, resp;
  logic [1:0]  op;
  logic [5:0]  addr;
  logic        in_bank, exec_err, wr_reg, wr_lock;
  logic [7:0]  rd_reg;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;
  logic        locked;

`ifdef SPI_WR_LOCK_EN
  localparam bit LockEn = 1'b1;

  // Lock flag: only the exact key 8'hA5 opens it, any other value closes it again.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      locked <= 1'b1;
    else if (state == EXEC && wr_lock)
      locked <= (data_q != 8'hA5);
  end
`else
  localparam bit LockEn = 1'b0;
  assign locked = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= word_rcvd;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign go      = sync2 & ~sync3;
  assign op      = cmd_q[7:6];
  assign addr    = cmd_q[5:0];
  assign in_bank = ({1'b0, addr} < 7'(NREG));
  assign busy    = (state != IDLE);

  always_comb begin
    rd_reg   = 8'h00;
    regs_out = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr == 6'(i))
        rd_reg = regs[i];
      regs_out[8*i +: 8] = regs[i];
    end
  end

  always_comb begin
    exec_err = 1'b0;
    wr_reg   = 1'b0;
    wr_lock  = 1'b0;
    resp     = {cmd_q, 8'h00};
    case (op)
      2'b00: resp = {cmd_q, err_cnt};
      2'b01: begin
        if (in_bank)             resp = {cmd_q, rd_reg};
        else if (addr == 6'h3C)  resp = {cmd_q, err_cnt};
        else if (addr == 6'h3D)  resp = {cmd_q, CHIP_ID};
        else if (addr == 6'h3E)  resp = {cmd_q, status_in};
        else if (addr == 6'h3F)  resp = {cmd_q, 7'd0, locked};
        else                     exec_err = 1'b1;
      end
      2'b10: begin
        if (in_bank && !locked) begin
          wr_reg = 1'b1;
          resp   = {cmd_q, data_q};
        end else if (addr == 6'h3F && LockEn) begin
          wr_lock = 1'b1;
          resp    = {cmd_q, 7'd0, (data_q != 8'hA5)};
        end else begin
          exec_err = 1'b1;
        end
      end
      default: exec_err = 1'b1;
    endcase
    if (exec_err)
      resp = {8'hFF, cmd_q};
  end

  // An execution error and an overrun go can land in the same cycle, so up to two counts at once.
  always_comb begin
    err_inc  = 2'(exec_err && state == EXEC) + 2'(go && state != IDLE);
    err_sum  = {1'b0, err_cnt} + {7'd0, err_inc};
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cmd_q     <= 8'h00;
      data_q    <= 8'h00;
      resp_q    <= 16'h0000;
      tx_buff   <= 16'h0000;
      wr_strobe <= 1'b0;
      wr_addr   <= 6'd0;
      err_cnt   <= 8'h00;
      for (int i = 0; i < NREG; i++)
        regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      err_cnt   <= err_next;
      case (state)
        IDLE: if (go) state <= CAPTURE;
        CAPTURE: begin
          cmd_q  <= cmd_byte;
          data_q <= data_byte;
          state  <= EXEC;
        end
        EXEC: begin
          resp_q <= resp;
          if (wr_reg) begin
            for (int i = 0; i < NREG; i++)
              if (addr == 6'(i))
                regs[i] <= data_q;
          end
          if (wr_reg || wr_lock) begin
            wr_strobe <= 1'b1;
            wr_addr   <= addr;
          end
          state <= RESP;
        end
        RESP: begin
          tx_buff <= resp_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: table vectors, random frames against a spec-level model, and corner sequences.
module tb_spi_reg_ctrl;
  localparam int         NREG    = 16;
  localparam logic [7:0] CHIP_ID = 8'h54;
`ifdef SPI_WR_LOCK_EN
  localparam bit LOCK_FEATURE = 1'b1;
`else
  localparam bit LOCK_FEATURE = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              word_rcvd;
  logic [7:0]        cmd_byte, data_byte, status_in;
  logic [15:0]       tx_buff;
  logic [8*NREG-1:0] regs_out;
  logic              wr_strobe;
  logic [5:0]        wr_addr;
  logic              busy;

  spi_reg_ctrl #(.NREG(NREG), .CHIP_ID(CHIP_ID)) dut (
    .CLK(CLK), .RST(RST), .word_rcvd(word_rcvd), .cmd_byte(cmd_byte),
    .data_byte(data_byte), .status_in(status_in), .tx_buff(tx_buff),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int strobe_total = 0;

  always @(negedge CLK) if (wr_strobe) strobe_total++;

  logic [7:0] m_regs [NREG];
  logic [7:0] m_err;
  bit         m_locked;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  data;
    logic [7:0]  status;
    logic [15:0] exp_tx;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_err    = 8'h00;
    m_locked = 1'b1;
  endtask

  task automatic model_err_bump();
    if (m_err != 8'hFF) m_err = m_err + 8'h01;
  endtask

  // Reference behaviour of one complete frame, straight from the opcode and address maps.
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] status,
                             output logic [15:0] exp_tx, output int exp_wr);
    int a;
    bit err;
    bit lk;
    a      = int'(cmd[5:0]);
    err    = 1'b0;
    exp_wr = 0;
    lk     = LOCK_FEATURE && m_locked;
    exp_tx = 16'h0000;
    case (cmd[7:6])
      2'd0: exp_tx = {cmd, m_err};
      2'd1: begin
        if (a < NREG)     exp_tx = {cmd, m_regs[a]};
        else if (a == 60) exp_tx = {cmd, m_err};
        else if (a == 61) exp_tx = {cmd, CHIP_ID};
        else if (a == 62) exp_tx = {cmd, status};
        else if (a == 63) exp_tx = {cmd, 7'd0, lk};
        else              err = 1'b1;
      end
      2'd2: begin
        if (a < NREG && !lk) begin
          m_regs[a] = data;
          exp_tx    = {cmd, data};
          exp_wr    = 1;
        end else if (a == 63 && LOCK_FEATURE) begin
          m_locked = (data != 8'hA5);
          exp_tx   = {cmd, 7'd0, m_locked};
          exp_wr   = 1;
        end else begin
          err = 1'b1;
        end
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      exp_tx = {8'hFF, cmd};
      model_err_bump();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    logic [8*NREG-1:0] exp_flat;
    for (int i = 0; i < NREG; i++) exp_flat[8*i +: 8] = m_regs[i];
    checks++;
    if (regs_out !== exp_flat) begin
      errors++;
      $display("[TB] FAIL %s regs: got %h, expected %h", name, regs_out, exp_flat);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(posedge CLK); #1;
    end
    chk({name, "_done"}, {31'd0, busy}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(input string name, input logic [7:0] cmd, input logic [7:0] data,
                                input logic [7:0] status);
    @(posedge CLK); #1;
    cmd_byte  = cmd;
    data_byte = data;
    status_in = status;
    word_rcvd = 1'b1;
    repeat (4) @(posedge CLK);
    #1 word_rcvd = 1'b0;
    wait_idle(name);
  endtask

  task automatic check_output(input string name, input logic [15:0] exp_tx, input int exp_wr,
                              input int strobes_before, input logic [5:0] exp_addr);
    chk({name, "_tx"}, {16'd0, tx_buff}, {16'd0, exp_tx});
    chk({name, "_strobes"}, strobe_total - strobes_before, exp_wr);
    if (exp_wr != 0) chk({name, "_wr_addr"}, {26'd0, wr_addr}, {26'd0, exp_addr});
    chk_regs(name);
  endtask

  task automatic run_frame(input string name, input logic [7:0] cmd, input logic [7:0] data,
                           input logic [7:0] status);
    logic [15:0] m_tx;
    int          m_wr;
    int          s0;
    model_frame(cmd, data, status, m_tx, m_wr);
    s0 = strobe_total;
    apply_stimulus(name, cmd, data, status);
    check_output(name, m_tx, m_wr, s0, cmd[5:0]);
  endtask

  initial begin
    logic [7:0]  c, d, s;
    logic [15:0] m_tx;
    int          m_wr, s0;

    RST = 1'b1; word_rcvd = 1'b0; cmd_byte = 8'h00; data_byte = 8'h00; status_in = 8'h00;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_tx", {16'd0, tx_buff}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("reset_wr_addr", {26'd0, wr_addr}, 32'd0);
    chk_regs("reset");
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    vecs.push_back('{8'h00, 8'h00, 8'h00, 16'h0000, "nop_first"});
    if (LOCK_FEATURE) vecs.push_back('{8'hBF, 8'hA5, 8'h00, 16'hBF00, "unlock"});
    vecs.push_back('{8'h83, 8'h5A, 8'h00, 16'h835A, "write_r3"});
    vecs.push_back('{8'h43, 8'h00, 8'h00, 16'h435A, "read_r3"});
    vecs.push_back('{8'h7D, 8'h00, 8'h00, 16'h7D54, "read_chip_id"});
    vecs.push_back('{8'h7E, 8'h00, 8'hC3, 16'h7EC3, "read_status"});
    vecs.push_back('{8'h7F, 8'h00, 8'h00, 16'h7F00, "read_lock"});
    vecs.push_back('{8'hC0, 8'h11, 8'h00, 16'hFFC0, "bad_opcode"});
    vecs.push_back('{8'hB0, 8'h22, 8'h00, 16'hFFB0, "write_unmapped"});
    vecs.push_back('{8'h00, 8'h00, 8'h00, 16'h0002, "nop_err_cnt"});

    foreach (vecs[k]) begin
      run_frame(vecs[k].name, vecs[k].cmd, vecs[k].data, vecs[k].status);
      chk({vecs[k].name, "_table"}, {16'd0, tx_buff}, {16'd0, vecs[k].exp_tx});
    end

    for (int n = 0; n < 60; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      c[7:6] = 2'($urandom_range(0, 3));
      if (r < 6)       c[5:0] = 6'($urandom_range(0, NREG - 1));
      else if (r < 8)  c[5:0] = 6'($urandom_range(60, 63));
      else             c[5:0] = 6'($urandom_range(NREG, 63));
      d = 8'($urandom);
      s = 8'($urandom);
      run_frame("random", c, d, s);
    end

    // A second word_rcvd edge lands while the first frame is still in flight.
    if (LOCK_FEATURE) run_frame("unlock2", 8'hBF, 8'hA5, 8'h00);
    model_frame(8'h87, 8'h3C, 8'h00, m_tx, m_wr);
    model_err_bump();
    s0 = strobe_total;
    @(posedge CLK); #1;
    cmd_byte = 8'h87; data_byte = 8'h3C; status_in = 8'h00; word_rcvd = 1'b1;
    repeat (2) @(posedge CLK);
    #1 word_rcvd = 1'b0;
    @(posedge CLK);
    #1 word_rcvd = 1'b1;
    chk("overrun_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge CLK);
    #1 word_rcvd = 1'b0;
    wait_idle("overrun");
    check_output("overrun", m_tx, m_wr, s0, 6'd7);
    run_frame("overrun_errcnt", 8'h7C, 8'h00, 8'h00);

    for (int n = 0; n < 300; n++)
      run_frame("saturate", {2'b11, 6'($urandom_range(0, 63))}, 8'h00, 8'h00);
    run_frame("sat_read", 8'h7C, 8'h00, 8'h00);
    chk("sat_value", {16'd0, tx_buff}, 32'h7CFF);

    // Reset lands while a write sits in EXEC; nothing of it may survive.
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    model_reset();
    s0 = strobe_total;
    @(posedge CLK); #1;
    cmd_byte = 8'h85; data_byte = 8'h77; word_rcvd = 1'b1;
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("rst_exec_busy", {31'd0, busy}, 32'd0);
    chk("rst_exec_tx", {16'd0, tx_buff}, 32'd0);
    chk("rst_exec_strobe", {31'd0, wr_strobe}, 32'd0);
    word_rcvd = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("rst_exec_no_strobe", strobe_total - s0, 0);
    chk("rst_exec_reg5", {24'd0, regs_out[8*5 +: 8]}, 32'd0);
    chk("rst_exec_tx_after", {16'd0, tx_buff}, 32'd0);
    chk_regs("rst_exec");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command decoder and register bank sitting directly downstream of the SPI shift core. Synchronises the core's end-of-word flag into the system clock domain, then captures the command and data bytes and executes a read or write on a small configuration register bank. Loads the 16-bit response into `tx_buff`, which the SPI core shifts out during the next frame.

## Interface
- `NREG`, default 16: number of writable 8-bit configuration registers, 1..32.
- `CHIP_ID`, default 8'h54: value returned at address 0x3D.
- `CLK` in 1: system clock, asynchronous to SCK.
- `RST` in 1: asynchronous, active-high reset.
- `word_rcvd` in 1: end-of-frame flag from the SPI core, SCK domain.
- `cmd_byte` in 8: `[7:6]` opcode, `[5:0]` address.
- `data_byte` in 8: write data.
- `status_in` in 8: live status, read-only at 0x3E.
- `tx_buff` out 16: response word for the next frame.
- `regs_out` out 8*NREG: flattened register bank; reg i is `[8i+7:8i]`.
- `wr_strobe` out 1: one-CLK pulse on every accepted register write.
- `wr_addr` out 6: address of the last accepted write.
- `busy` out 1: high while the FSM is not IDLE.

## Operation
- **Synchroniser**
  - `word_rcvd` passes through a 2-flop synchroniser, then a rising-edge detector; the edge produces `go`.
  - `cmd_byte` and `data_byte` are only sampled in CAPTURE, after synchronisation, when they are stable.
- **FSM states:** IDLE, CAPTURE, EXEC, RESP.
  - IDLE → CAPTURE on `go`.
  - CAPTURE: latch cmd and data → EXEC.
  - EXEC: perform the access → RESP.
  - RESP: update `tx_buff` → IDLE.
- **Opcodes**
  - 00 NOP: `tx_buff={cmd,err_cnt}`.
  - 01 READ: `tx_buff={cmd,rd}`.
  - 10 WRITE: write `data` to `addr`, then `tx_buff={cmd,reg[addr]}`. The readback is the post-write value.
  - 11: invalid.
- **Read map**
  - 0..NREG-1: registers.
  - 0x3C: `err_cnt`.
  - 0x3D: `CHIP_ID`.
  - 0x3E: `status_in`.
  - 0x3F: lock state; see Configuration.
- **Write map**
  - Only addresses 0..NREG-1 are writable, plus 0x3F when `SPI_WR_LOCK_EN` is defined.
- **Errors**
  - Error cases: invalid opcode, READ of an unmapped address, or WRITE to a non-writable address.
  - Response: `tx_buff={8'hFF,cmd}`, no register change, no `wr_strobe`.
  - `err_cnt` (8 bit) increments and saturates at 8'hFF.
- **Overrun:** a `go` arriving while not IDLE is dropped and increments `err_cnt`. The operation in progress completes normally.
- **Reset values** (all outputs): `tx_buff`=0, `regs_out`=0, `wr_strobe`=0, `wr_addr`=0, `busy`=0, `err_cnt`=0, synchroniser flops 0, FSM=IDLE.
- **Reset mid-operation:** abort immediately; any access still in EXEC is lost.

## Timing
- Let `go` be asserted in CLK cycle n.
  - n+1: CAPTURE.
  - n+2: EXEC; register write takes effect at the end of this cycle.
  - `wr_strobe`, `wr_addr` and `regs_out` change at the n+3 edge.
  - n+3: RESP; `tx_buff` valid from the n+4 edge; `busy` high cycles n+1..n+3.
- Worst-case `word_rcvd` rise to valid `tx_buff`: 7 CLK (sync 2, edge 1, FSM 3, plus 1 phase).
- System constraints:
  - `word_rcvd` must stay high for ≥3 CLK.
  - CS must stay high for ≥8 CLK before the first SCK falling edge of the next frame.
  - `tx_buff` changes only in RESP, so it is stable during a frame.
- `cmd_byte` is overwritten 8 SCK into the next frame. CAPTURE must therefore complete before then; this is guaranteed by the CS-high constraint.

## Configuration
- **`SPI_WR_LOCK_EN` defined**
  - A lock flag resets to locked (0x3F reads 8'h01).
  - WRITE of 8'hA5 to 0x3F unlocks (reads 8'h00); WRITE of any other value to 0x3F relocks.
  - While locked, a WRITE to 0..NREG-1 is an error: response `{8'hFF,cmd}`, `err_cnt`+1, no write.
  - A WRITE to 0x3F is always accepted and pulses `wr_strobe`.
- **Not defined**
  - No lock flag; 0x3F reads 8'h00.
  - WRITE to 0x3F is an error.
  - Writes to 0..NREG-1 are always accepted.

## Test plan
- Reset, then a NOP frame (cmd 8'h00) → `tx_buff`=16'h0000 and all `regs_out`=0.
- With the lock feature built in:
  - WRITE 0x3F=8'hA5 (cmd 8'hBF), then WRITE reg 3=8'h5A (cmd 8'h83) → one `wr_strobe` per write, `wr_addr`=3.
  - Then READ reg 3 (cmd 8'h43) → `tx_buff`=16'h435A.
- READ 0x3D (cmd 8'h7D) → `tx_buff`=16'h7D54; READ 0x3E with `status_in`=8'hC3 → 16'h7EC3.
- Invalid opcode (cmd 8'hC0) and WRITE to 0x30 with NREG=16 → each gives `tx_buff`=16'hFF<cmd>; then NOP → `tx_buff`=16'h0002.
- Second `word_rcvd` pulse injected at n+1 → dropped, `err_cnt`+1, first access completes; 300 invalid commands → `err_cnt` saturates at 8'hFF.
- Assert `RST` during EXEC of a WRITE → target register stays 0, no `wr_strobe`, `busy`=0 immediately, `tx_buff`=0.
